// File: rtl/uart_rx_fifo.sv
// UART receiver with a 16x-oversampled framing FSM, parity/stop checking and a
// show-ahead FIFO for accepted bytes. Error flags are sticky until err_clr.
module uart_rx_fifo #(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int PARITY_MODE  = 1,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rx,
  input  logic               rd_en,
  input  logic               err_clr,
  output logic [7:0]         rd_data,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   count,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overflow
);

  localparam int DIV   = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int TW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW    = FIFO_AW + 1;
  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic ones_odd(input logic [8:0] v);
    return ^v;
  endfunction

  logic          rx_s1_q, rx_s2_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick_s;

  assign tick_s = (tick_cnt_q == TW'(DIV - 1));

  // Line synchroniser and free-running oversample tick.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      tick_cnt_q <= '0;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      if (tick_s) tick_cnt_q <= '0;
      else        tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  state_t     state_q;
  logic [3:0] os_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       par_bad_q;

  // Framing FSM; samples the synchronised line mid-bit.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      os_q      <= 4'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      par_bad_q <= 1'b0;
    end else if (tick_s) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s2_q) begin
            state_q <= ST_START;
            os_q    <= 4'd0;
          end
        end
        ST_START: begin
          if (os_q == 4'd7) begin
            os_q <= 4'd0;
            if (!rx_s2_q) begin
              state_q   <= ST_DATA;
              bit_q     <= 3'd0;
              par_bad_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            os_q <= os_q + 4'd1;
          end
        end
        ST_DATA: begin
          if (os_q == 4'd15) begin
            shift_q <= {rx_s2_q, shift_q[7:1]};
            os_q    <= 4'd0;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
          end else begin
            os_q <= os_q + 4'd1;
          end
        end
        ST_PARITY: begin
          if (os_q == 4'd15) begin
            par_bad_q <= (PARITY_MODE == 1) ? !ones_odd({shift_q, rx_s2_q})
                                            :  ones_odd({shift_q, rx_s2_q});
            os_q      <= 4'd0;
            state_q   <= ST_STOP;
          end else begin
            os_q <= os_q + 4'd1;
          end
        end
        ST_STOP: begin
          os_q <= (os_q == 4'd15) ? 4'd0 : os_q + 4'd1;
          if (os_q == 4'd15) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          os_q    <= 4'd0;
        end
      endcase
    end
  end

  logic          done_s, good_s, pop_s, push_s;
  logic          pe_set_s, fe_set_s, ovf_set_s;
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          empty_q, full_q, pe_q, pe_d, fe_q, fe_d, ovf_q, ovf_d;

  // Frame completion, FIFO next-state and sticky flag next-state.
  always_comb begin
    done_s    = tick_s && (state_q == ST_STOP) && (os_q == 4'd15);
    fe_set_s  = done_s && !rx_s2_q;
    pe_set_s  = done_s && par_bad_q;
    good_s    = done_s && rx_s2_q && !par_bad_q;
    pop_s     = rd_en && !empty_q;
    push_s    = good_s && (!full_q || pop_s);
    ovf_set_s = good_s && full_q && !pop_s;
    wr_ptr_d  = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
    // New head is the incoming byte when it lands exactly at the read pointer.
    if (count_d == '0) rd_data_d = rd_data_q;
    else if (push_s && (rd_ptr_d == wr_ptr_q)) rd_data_d = shift_q;
    else rd_data_d = mem_q[rd_ptr_d[FIFO_AW-1:0]];
    pe_d  = pe_set_s  ? 1'b1 : (err_clr ? 1'b0 : pe_q);
    fe_d  = fe_set_s  ? 1'b1 : (err_clr ? 1'b0 : fe_q);
    ovf_d = ovf_set_s ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
  end

  // FIFO storage.
  always_ff @(posedge clk_in) begin
    if (push_s) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= shift_q;
  end

  // FIFO control and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      rd_data_q <= 8'd0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= (count_d == '0);
      full_q    <= (count_d == PW'(DEPTH));
      rd_data_q <= rd_data_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      ovf_q     <= ovf_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign count      = count_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences
// and random frames checked against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          rx = 1'b1;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [7:0]    rd_data;
  logic          empty, full, parity_err, frame_err, overflow;
  logic [AW:0]   count;

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0] mq[$];
  bit m_pe, m_fe, m_ovf;

  uart_rx_fifo #(
    .SYS_CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .PARITY_MODE(1), .FIFO_AW(AW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rx(rx), .rd_en(rd_en), .err_clr(err_clr),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm);
    chk({nm, ".count"}, 32'(count), 32'(mq.size()));
    chk({nm, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({nm, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
    if (mq.size() > 0) chk({nm, ".rd_data"}, 32'(rd_data), 32'(mq[0]));
    chk({nm, ".parity_err"}, 32'(parity_err), 32'(m_pe));
    chk({nm, ".frame_err"}, 32'(frame_err), 32'(m_fe));
    chk({nm, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Drive one 11-bit odd-parity frame, 16 clocks per bit; optionally pop on the stop-sample cycle.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_b, input bit pop_done);
    logic [10:0] fb;
    bit par;
    par = ($countones(d) % 2 == 0);
    if (bad_par) par = !par;
    fb = {stop_b, par, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      for (int i = 0; i < 16; i++) begin
        @(negedge clk_in);
        rx = fb[b];
        rd_en = pop_done && (b == 10) && (i == 10);
      end
    end
    @(negedge clk_in);
    rx = 1'b1;
    rd_en = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit stop_b, input bit pop_done);
    if (pop_done && mq.size() > 0) void'(mq.pop_front());
    if (!stop_b) m_fe = 1'b1;
    if (bad_par) m_pe = 1'b1;
    if (stop_b && !bad_par) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic xfer(input logic [7:0] d, input bit bad_par, input bit stop_b, input bit pop_done);
    send_frame(d, bad_par, stop_b, pop_done);
    model_frame(d, bad_par, stop_b, pop_done);
  endtask

  task automatic pop_one();
    @(negedge clk_in);
    rd_en = 1'b1;
    @(negedge clk_in);
    rd_en = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic clear_errs();
    @(negedge clk_in);
    err_clr = 1'b1;
    @(negedge clk_in);
    err_clr = 1'b0;
    m_pe = 1'b0; m_fe = 1'b0; m_ovf = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    bit bad_par;
    bit stop_b;
    bit exp_pe;
    bit exp_fe;
    int exp_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[5] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1};

    #12;
    check_all("reset_held");
    chk("reset.rd_data", 32'(rd_data), 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check_all("after_reset");

    foreach (vecs[k]) begin
      xfer(vecs[k].d, vecs[k].bad_par, vecs[k].stop_b, 1'b0);
      chk($sformatf("vec%0d.parity_err", k), 32'(parity_err), 32'(vecs[k].exp_pe));
      chk($sformatf("vec%0d.frame_err", k), 32'(frame_err), 32'(vecs[k].exp_fe));
      chk($sformatf("vec%0d.count", k), 32'(count), 32'(vecs[k].exp_cnt));
      chk($sformatf("vec%0d.empty", k), 32'(empty), 32'(vecs[k].exp_cnt == 0));
      if (vecs[k].exp_cnt != 0) chk($sformatf("vec%0d.rd_data", k), 32'(rd_data), 32'(vecs[k].d));
      check_all($sformatf("vec%0d.model", k));
      while (mq.size() > 0) pop_one();
      clear_errs();
      check_all($sformatf("vec%0d.cleared", k));
    end

    xfer(8'h41, 1'b0, 1'b1, 1'b0);
    xfer(8'h42, 1'b0, 1'b1, 1'b0);
    xfer(8'h43, 1'b0, 1'b1, 1'b0);
    check_all("b2b.filled");
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b.read%0d", i), 32'(rd_data), 32'(8'h41 + i));
      pop_one();
    end
    check_all("b2b.drained");
    pop_one();
    check_all("pop_empty");

    xfer(8'hA5, 1'b0, 1'b0, 1'b0);
    check_all("stop0");
    xfer(8'h5A, 1'b0, 1'b1, 1'b0);
    check_all("after_stop0");
    pop_one();
    clear_errs();

    @(negedge clk_in);
    rx = 1'b0;
    repeat (4) @(negedge clk_in);
    rx = 1'b1;
    repeat (40) @(negedge clk_in);
    check_all("glitch");
    xfer(8'hC3, 1'b0, 1'b1, 1'b0);
    check_all("after_glitch");
    pop_one();

    for (int i = 0; i < DEPTH; i++) xfer(8'(i), 1'b0, 1'b1, 1'b0);
    check_all("fill16");
    xfer(8'hFF, 1'b0, 1'b1, 1'b0);
    check_all("overflow");
    chk("overflow.head", 32'(rd_data), 32'h00);
    clear_errs();
    xfer(8'hFF, 1'b0, 1'b1, 1'b1);
    check_all("full_push_pop");
    chk("full_push_pop.count", 32'(count), 32'd16);
    chk("full_push_pop.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check_all($sformatf("drain%0d", i));
      pop_one();
    end
    check_all("drained");

    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      bit bp, sb;
      d = 8'($urandom);
      bp = ($urandom_range(0, 7) == 0);
      sb = ($urandom_range(0, 7) != 0);
      xfer(d, bp, sb, 1'b0);
      check_all($sformatf("rnd%0d", n));
      for (int p = $urandom_range(0, 2); p > 0; p--) begin
        pop_one();
        check_all($sformatf("rnd%0d.pop", n));
      end
      if ($urandom_range(0, 3) == 0) clear_errs();
    end

    xfer(8'h11, 1'b1, 1'b1, 1'b0);
    xfer(8'h22, 1'b0, 1'b1, 1'b0);
    @(negedge clk_in);
    rx = 1'b0;
    repeat (16 + 16 * 4) @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    mq.delete();
    m_pe = 1'b0; m_fe = 1'b0; m_ovf = 1'b0;
    check_all("async_reset");
    chk("async_reset.rd_data", 32'(rd_data), 32'h0);
    rx = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    xfer(8'h3C, 1'b0, 1'b1, 1'b0);
    check_all("after_async_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
